// File: rtl/router_fifo_pkt.sv
// Packet-aware output FIFO: tags header words, tracks remaining packet bytes on read, sticky error flags.
// Read latency 1 cycle; writes when full and reads when empty are dropped and latch overflow/underflow.
module router_fifo_pkt #(
   parameter int DATA_W    = 8,
   parameter int DEPTH     = 16,
   parameter int LEN_LSB   = 2,
   parameter int AFULL_TH  = DEPTH - 2,
   parameter int AEMPTY_TH = 2
) (
   input  logic                     clock,
   input  logic                     resetn,
   input  logic                     soft_reset,
   input  logic                     write_enb,
   input  logic                     read_enb,
   input  logic                     lfd_state,
   input  logic [DATA_W-1:0]        data_in,
   output logic [DATA_W-1:0]        data_out,
   output logic                     out_valid,
   output logic                     full,
   output logic                     empty,
   output logic                     almost_full,
   output logic                     almost_empty,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     pkt_busy,
   output logic                     overflow,
   output logic                     underflow
);
   localparam int AW  = $clog2(DEPTH);
   localparam int AWP = AW + 1;
   localparam int LW  = DATA_W - LEN_LSB;
   localparam int LWP = LW + 1;
   localparam logic [AW:0] AFULL_L  = AWP'(AFULL_TH);
   localparam logic [AW:0] AEMPTY_L = AWP'(AEMPTY_TH);

   logic [DATA_W:0]   mem_q [DEPTH];
   logic [AW:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [LW:0]       cnt_q, cnt_d;
   logic              lfd_q, lfd_d;
   logic [DATA_W-1:0] dout_q, dout_d;
   logic              vld_q, vld_d;
   logic              ovf_q, ovf_d, unf_q, unf_d;
   logic              wr_acc, rd_acc;
   logic [DATA_W:0]   rd_entry;

   // Extra pointer MSB distinguishes full from empty when the index bits match.
   assign full         = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign empty        = (wr_ptr_q == rd_ptr_q);
   assign level        = wr_ptr_q - rd_ptr_q;
   assign almost_full  = (level >= AFULL_L);
   assign almost_empty = (level <= AEMPTY_L);
   assign pkt_busy     = (cnt_q != '0);
   assign data_out     = dout_q;
   assign out_valid    = vld_q;
   assign overflow     = ovf_q;
   assign underflow    = unf_q;

   assign wr_acc   = write_enb && !full;
   assign rd_acc   = read_enb && !empty;
   assign rd_entry = mem_q[rd_ptr_q[AW-1:0]];

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      lfd_d    = lfd_state;
      dout_d   = dout_q;
      vld_d    = 1'b0;
      ovf_d    = ovf_q;
      unf_d    = unf_q;
      if (soft_reset) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         cnt_d    = '0;
         lfd_d    = 1'b0;
         dout_d   = '0;
         ovf_d    = 1'b0;
         unf_d    = 1'b0;
      end else begin
         if (wr_acc) wr_ptr_d = wr_ptr_q + AWP'(1);
         if (write_enb && full) ovf_d = 1'b1;
         if (read_enb && empty) unf_d = 1'b1;
         if (rd_acc) begin
            rd_ptr_d = rd_ptr_q + AWP'(1);
            dout_d   = rd_entry[DATA_W-1:0];
            vld_d    = 1'b1;
            // Header reload counts payload bytes plus the trailing parity byte.
            if (rd_entry[DATA_W])
               cnt_d = {1'b0, rd_entry[DATA_W-1:LEN_LSB]} + LWP'(1);
            else if (cnt_q != '0)
               cnt_d = cnt_q - LWP'(1);
         end else if (cnt_q == '0) begin
            dout_d = '0;
         end
      end
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
         lfd_q    <= 1'b0;
         dout_q   <= '0;
         vld_q    <= 1'b0;
         ovf_q    <= 1'b0;
         unf_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
         lfd_q    <= lfd_d;
         dout_q   <= dout_d;
         vld_q    <= vld_d;
         ovf_q    <= ovf_d;
         unf_q    <= unf_d;
      end
   end

   // Storage is not reset; pointers alone define valid contents.
   always_ff @(posedge clock) begin
      if (wr_acc && !soft_reset)
         mem_q[wr_ptr_q[AW-1:0]] <= {lfd_q, data_in};
   end
endmodule
